// File: rtl/bwt_table_loader.sv
// Loads the C, Occ and read/D lookup memories from a byte stream: parses a
// two-byte header, assembles entries and issues one registered write strobe per entry.
module bwt_table_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        we_C,
  output logic [1:0]  waddr_C,
  output logic [7:0]  wdata_C,
  output logic        we_Occ,
  output logic [7:0]  waddr_Occ,
  output logic [31:0] wdata_Occ,
  output logic        we_rd,
  output logic [7:0]  waddr_rd,
  output logic [7:0]  wdata_d,
  output logic [1:0]  wdata_read,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_CTBL = 3'd3;
  localparam logic [2:0] S_OCC  = 3'd4;
  localparam logic [2:0] S_RD   = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  occ_last_q, occ_last_d;
  logic [7:0]  rd_last_q, rd_last_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] asm_q, asm_d;
  logic [7:0]  rd_byte_q, rd_byte_d;
  logic [7:0]  occ_cnt_q, occ_cnt_d;
  logic [7:0]  rd_cnt_q, rd_cnt_d;
  logic        we_c_q, we_c_d;
  logic [1:0]  waddr_c_q, waddr_c_d;
  logic [7:0]  wdata_c_q, wdata_c_d;
  logic        we_occ_q, we_occ_d;
  logic [7:0]  waddr_occ_q, waddr_occ_d;
  logic [31:0] wdata_occ_q, wdata_occ_d;
  logic        we_rd_q, we_rd_d;
  logic [7:0]  waddr_rd_q, waddr_rd_d;
  logic [7:0]  wdata_d_q, wdata_d_d;
  logic [1:0]  wdata_read_q, wdata_read_d;
  logic        err_q, err_d;
  logic        accept;

  assign in_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_CTBL) ||
                    (state_q == S_OCC)  || (state_q == S_RD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    occ_last_d   = occ_last_q;
    rd_last_d    = rd_last_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    rd_byte_d    = rd_byte_q;
    occ_cnt_d    = occ_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    we_c_d       = 1'b0;
    waddr_c_d    = waddr_c_q;
    wdata_c_d    = wdata_c_q;
    we_occ_d     = 1'b0;
    waddr_occ_d  = waddr_occ_q;
    wdata_occ_d  = wdata_occ_q;
    we_rd_d      = 1'b0;
    waddr_rd_d   = waddr_rd_q;
    wdata_d_d    = wdata_d_q;
    wdata_read_d = wdata_read_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_HDR0;
          err_d      = 1'b0;
          byte_idx_d = 2'd0;
          asm_d      = 32'd0;
          occ_cnt_d  = 8'd0;
          rd_cnt_d   = 8'd0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          occ_last_d = in_data;
          state_d    = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          rd_last_d  = in_data;
          byte_idx_d = 2'd0;
          state_d    = S_CTBL;
        end
      end
      S_CTBL: begin
        if (accept) begin
          we_c_d     = 1'b1;
          waddr_c_d  = byte_idx_q;
          wdata_c_d  = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_OCC;
        end
      end
      S_OCC: begin
        if (accept) begin
          // Little-endian: the first (A) byte ends up in [7:0] after four shifts.
          asm_d      = {in_data, asm_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_occ_d    = 1'b1;
            waddr_occ_d = occ_cnt_q;
            wdata_occ_d = {in_data, asm_q[31:8]};
            occ_cnt_d   = occ_cnt_q + 8'd1;
            if (occ_cnt_q == occ_last_q) state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (accept) begin
          if (byte_idx_q[0] == 1'b0) begin
            rd_byte_d  = in_data;
            byte_idx_d = 2'd1;
          end else begin
            we_rd_d      = 1'b1;
            waddr_rd_d   = rd_cnt_q;
            wdata_d_d    = rd_byte_q;
            wdata_read_d = in_data[1:0];
            if (in_data[7:2] != 6'd0) err_d = 1'b1;
            rd_cnt_d     = rd_cnt_q + 8'd1;
            byte_idx_d   = 2'd0;
            if (rd_cnt_q == rd_last_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any byte accepted on the same edge: no strobe, no error update.
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      we_c_d     = 1'b0;
      we_occ_d   = 1'b0;
      we_rd_d    = 1'b0;
      err_d      = err_q;
      byte_idx_d = 2'd0;
      asm_d      = 32'd0;
      rd_byte_d  = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      occ_last_q   <= 8'd0;
      rd_last_q    <= 8'd0;
      byte_idx_q   <= 2'd0;
      asm_q        <= 32'd0;
      rd_byte_q    <= 8'd0;
      occ_cnt_q    <= 8'd0;
      rd_cnt_q     <= 8'd0;
      we_c_q       <= 1'b0;
      waddr_c_q    <= 2'd0;
      wdata_c_q    <= 8'd0;
      we_occ_q     <= 1'b0;
      waddr_occ_q  <= 8'd0;
      wdata_occ_q  <= 32'd0;
      we_rd_q      <= 1'b0;
      waddr_rd_q   <= 8'd0;
      wdata_d_q    <= 8'd0;
      wdata_read_q <= 2'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_last_q   <= occ_last_d;
      rd_last_q    <= rd_last_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      rd_byte_q    <= rd_byte_d;
      occ_cnt_q    <= occ_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      we_c_q       <= we_c_d;
      waddr_c_q    <= waddr_c_d;
      wdata_c_q    <= wdata_c_d;
      we_occ_q     <= we_occ_d;
      waddr_occ_q  <= waddr_occ_d;
      wdata_occ_q  <= wdata_occ_d;
      we_rd_q      <= we_rd_d;
      waddr_rd_q   <= waddr_rd_d;
      wdata_d_q    <= wdata_d_d;
      wdata_read_q <= wdata_read_d;
      err_q        <= err_d;
    end
  end

  assign we_C       = we_c_q;
  assign waddr_C    = waddr_c_q;
  assign wdata_C    = wdata_c_q;
  assign we_Occ     = we_occ_q;
  assign waddr_Occ  = waddr_occ_q;
  assign wdata_Occ  = wdata_occ_q;
  assign we_rd      = we_rd_q;
  assign waddr_rd   = waddr_rd_q;
  assign wdata_d    = wdata_d_q;
  assign wdata_read = wdata_read_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_bwt_table_loader.sv
// Directed bench for bwt_table_loader: expected memory writes are queued as
// bytes are scheduled and matched against every strobe the loader emits.
module tb_bwt_table_loader;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, we_C, we_Occ, we_rd, busy, done, err;
  logic [1:0]  waddr_C, wdata_read;
  logic [7:0]  wdata_C, waddr_Occ, waddr_rd, wdata_d;
  logic [31:0] wdata_Occ;

  always #5 clk = ~clk;

  bwt_table_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .we_C(we_C), .waddr_C(waddr_C), .wdata_C(wdata_C),
    .we_Occ(we_Occ), .waddr_Occ(waddr_Occ), .wdata_Occ(wdata_Occ),
    .we_rd(we_rd), .waddr_rd(waddr_rd), .wdata_d(wdata_d), .wdata_read(wdata_read),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0;
  int done_cnt = 0, strobe_cnt = 0;
  logic [41:0] sb_q[$];
  logic [7:0]  st_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [41:0] enc(input logic [1:0] kind, input logic [7:0] addr,
                                      input logic [31:0] data);
    return {kind, addr, data};
  endfunction

  task automatic mon(input logic [41:0] obs);
    strobe_cnt++;
    if (sb_q.size() == 0) check("unexpected_strobe", obs, 0);
    else check("write", obs, sb_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (we_C || we_Occ || we_rd) check("one_strobe", int'(we_C) + int'(we_Occ) + int'(we_rd), 1);
    if (we_C)   mon(enc(2'd1, {6'd0, waddr_C}, {24'd0, wdata_C}));
    if (we_Occ) mon(enc(2'd2, waddr_Occ, wdata_Occ));
    if (we_rd)  mon(enc(2'd3, waddr_rd, {22'd0, wdata_d, wdata_read}));
  end

  task automatic add_hdr(input logic [7:0] occ_last, input logic [7:0] rd_last);
    st_q.push_back(occ_last);
    st_q.push_back(rd_last);
  endtask

  task automatic add_c(input logic [7:0] a, input logic [7:0] c, input logic [7:0] g,
                       input logic [7:0] t);
    logic [7:0] v [4];
    v = '{a, c, g, t};
    for (int k = 0; k < 4; k++) begin
      st_q.push_back(v[k]);
      sb_q.push_back(enc(2'd1, 8'(k), {24'd0, v[k]}));
    end
  endtask

  task automatic add_occ(input logic [7:0] addr, input logic [31:0] w);
    st_q.push_back(w[7:0]);
    st_q.push_back(w[15:8]);
    st_q.push_back(w[23:16]);
    st_q.push_back(w[31:24]);
    sb_q.push_back(enc(2'd2, addr, w));
  endtask

  task automatic add_rd(input logic [7:0] addr, input logic [7:0] d, input logic [7:0] b1);
    st_q.push_back(d);
    st_q.push_back(b1);
    sb_q.push_back(enc(2'd3, addr, {22'd0, d, b1[1:0]}));
  endtask

  task automatic build_min();
    add_hdr(8'h00, 8'h00);
    add_c(8'h01, 8'h02, 8'h03, 8'h04);
    add_occ(8'd0, 32'h44332211);
    add_rd(8'd0, 8'h5A, 8'h03);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_all(input bit gap);
    bit first = 1'b1;
    while (st_q.size() != 0) begin
      logic [7:0] b;
      int n = 0;
      b = st_q.pop_front();
      if (gap && !first) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      first = 1'b0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int n = 0;
    in_valid = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
    check("done_latency", cyc - start_cyc, exp_lat);
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit gap);
    int nb;
    nb = st_q.size();
    pulse_start();
    send_all(gap);
    wait_done(gap ? 2 * nb - 1 : nb);
  endtask

  logic [74:0] all_out;
  assign all_out = {in_ready, we_C, waddr_C, wdata_C, we_Occ, waddr_Occ, wdata_Occ,
                    we_rd, waddr_rd, wdata_d, wdata_read, busy, done, err};

  initial begin
    int d0, s0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_out, 0);
    rst_n = 1'b1;

    // start together with abort in IDLE must not begin a load
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {busy, in_ready}, 2'b00);

    // minimal load
    d0 = done_cnt;
    build_min();
    run_load(1'b0);
    repeat (2) @(negedge clk);
    check("min_err", err, 1'b0);
    check("min_sb_empty", sb_q.size(), 0);
    check("min_done_once", done_cnt - d0, 1);
    check("min_idle", {busy, in_ready}, 2'b00);

    // backpressure: in_valid low every other cycle
    d0 = done_cnt; s0 = strobe_cnt;
    build_min();
    run_load(1'b1);
    repeat (2) @(negedge clk);
    check("bp_sb_empty", sb_q.size(), 0);
    check("bp_strobes", strobe_cnt - s0, 6);
    check("bp_done_once", done_cnt - d0, 1);

    // full tables: 256 Occ words and 256 read entries, no wrap write
    d0 = done_cnt; s0 = strobe_cnt;
    add_hdr(8'hFF, 8'hFF);
    add_c(8'hA0, 8'hB1, 8'hC2, 8'hD3);
    for (int i = 0; i < 256; i++) add_occ(8'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 256; i++) add_rd(8'(i), 8'(i) ^ 8'hA5, {6'd0, 2'(i)});
    run_load(1'b0);
    repeat (4) @(negedge clk);
    check("full_sb_empty", sb_q.size(), 0);
    check("full_strobes", strobe_cnt - s0, 516);
    check("full_last_occ_addr", waddr_Occ, 8'd255);
    check("full_last_rd_addr", waddr_rd, 8'd255);
    check("full_done_once", done_cnt - d0, 1);
    check("full_err", err, 1'b0);

    // format error in read byte1, load still completes
    d0 = done_cnt;
    add_hdr(8'h00, 8'h01);
    add_c(8'h10, 8'h20, 8'h30, 8'h40);
    add_occ(8'd0, 32'hDEADBEEF);
    add_rd(8'd0, 8'h12, 8'h86);
    add_rd(8'd1, 8'h34, 8'h01);
    run_load(1'b0);
    check("fmt_err_set", err, 1'b1);
    check("fmt_done_once", done_cnt - d0, 1);
    check("fmt_sb_empty", sb_q.size(), 0);
    build_min();
    pulse_start();
    check("fmt_err_cleared", err, 1'b0);
    check("fmt_busy", busy, 1'b1);
    send_all(1'b0);
    wait_done(12);
    check("fmt_err_after", err, 1'b0);

    // abort in OCC after two bytes of entry 3
    d0 = done_cnt; s0 = strobe_cnt;
    add_hdr(8'h04, 8'h00);
    add_c(8'h01, 8'h01, 8'h01, 8'h01);
    for (int i = 0; i < 3; i++) add_occ(8'(i), 32'h11111111 * 32'(i + 1));
    st_q.push_back(8'hAA);
    st_q.push_back(8'hBB);
    pulse_start();
    send_all(1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", {busy, in_ready}, 2'b00);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_strobes", strobe_cnt - s0, 7);
    check("abort_sb_empty", sb_q.size(), 0);
    build_min();
    run_load(1'b0);
    repeat (2) @(negedge clk);
    check("post_abort_sb_empty", sb_q.size(), 0);

    // reset in the middle of RD
    add_hdr(8'h00, 8'h02);
    add_c(8'h05, 8'h06, 8'h07, 8'h08);
    add_occ(8'd0, 32'h01020304);
    add_rd(8'd0, 8'h77, 8'h02);
    st_q.push_back(8'h99);
    pulse_start();
    send_all(1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_rd_outputs", all_out, 0);
    rst_n = 1'b1;
    check("rst_sb_empty", sb_q.size(), 0);
    d0 = done_cnt;
    build_min();
    run_load(1'b0);
    repeat (2) @(negedge clk);
    check("post_rst_sb_empty", sb_q.size(), 0);
    check("post_rst_done_once", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
